// File: rtl/shared_arb_pkg.sv
// shared_arb_pkg: owner encodings, tag format and default depth for the shared-resource arbiter
package shared_arb_pkg;
    localparam logic OWNER_P1 = 1'b0;
    localparam logic OWNER_P2 = 1'b1;
    localparam int DEPTH_DEF = 4;
    typedef struct packed {
        logic owner;
        logic kill;
    } tag_t;
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: in-order owner tags of outstanding requests with per-owner broadcast kill
module arb_tag_fifo
    import shared_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_owner,
    input  logic pop,
    input  logic kill_p1,
    input  logic kill_p2,
    output tag_t head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    tag_t mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0] count;
    assign head = mem[rd];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // kill marks every tag of a flushing owner; a fresh push always starts live
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if ((mem[i].owner == OWNER_P1) ? kill_p1 : kill_p2) mem[i].kill <= 1'b1;
            if (push) begin
                mem[wr] <= '{owner: push_owner, kill: 1'b0};
                wr <= wr + AW'(1);
            end
            if (pop) rd <= rd + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/shared_resource_arbiter.sv
// shared_resource_arbiter: round-robin merge of two pipelines onto one resource with tagged response return
module shared_resource_arbiter
    import shared_arb_pkg::*;
#(
    parameter int DW = 32,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] req_data_1,
    input  logic          req_valid_1,
    input  logic          req_flush_1,
    output logic          req_stall_1,
    output logic [DW-1:0] rsp_data_1,
    output logic          rsp_valid_1,
    input  logic          rsp_stall_1,
    input  logic [DW-1:0] req_data_2,
    input  logic          req_valid_2,
    input  logic          req_flush_2,
    output logic          req_stall_2,
    output logic [DW-1:0] rsp_data_2,
    output logic          rsp_valid_2,
    input  logic          rsp_stall_2,
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_stall,
    input  logic [DW-1:0] res_rsp_data,
    input  logic          res_rsp_valid,
    output logic          res_rsp_stall,
    output logic          err_orphan
);
    logic rr_last, full, empty, slot_free, acc_1, acc_2, grant_1, live, own_stall, pop;
    tag_t head;
    arb_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(acc_1 | acc_2),
        .push_owner(acc_1 ? OWNER_P1 : OWNER_P2),
        .pop(pop),
        .kill_p1(req_flush_1),
        .kill_p2(req_flush_2),
        .head(head),
        .full(full),
        .empty(empty)
    );
    // grant selection and response routing; full is a registered check so a same-cycle pop never frees a slot
    always_comb begin
        slot_free = !res_valid | !res_stall;
        grant_1 = req_valid_1 & !req_flush_1 & (!(req_valid_2 & !req_flush_2) | rr_last == OWNER_P2);
        acc_1 = slot_free & !full & grant_1;
        acc_2 = slot_free & !full & !grant_1 & req_valid_2 & !req_flush_2;
        req_stall_1 = req_valid_1 & !acc_1;
        req_stall_2 = req_valid_2 & !acc_2;
        live = res_rsp_valid & !empty & !head.kill &
               !((head.owner == OWNER_P1) ? req_flush_1 : req_flush_2);
        own_stall = (head.owner == OWNER_P1) ? rsp_stall_1 : rsp_stall_2;
        rsp_valid_1 = live & head.owner == OWNER_P1;
        rsp_valid_2 = live & head.owner == OWNER_P2;
        rsp_data_1 = rsp_valid_1 ? res_rsp_data : '0;
        rsp_data_2 = rsp_valid_2 ? res_rsp_data : '0;
        res_rsp_stall = live & own_stall;
        pop = res_rsp_valid & !empty & !(live & own_stall);
    end
    // output request register, round-robin history and sticky orphan flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data <= '0;
            rr_last <= OWNER_P2;
            err_orphan <= 1'b0;
        end else begin
            if (acc_1 | acc_2) begin
                res_valid <= 1'b1;
                res_data <= acc_1 ? req_data_1 : req_data_2;
                rr_last <= acc_1 ? OWNER_P1 : OWNER_P2;
            end else if (slot_free) begin
                res_valid <= 1'b0;
            end
            if (res_rsp_valid & empty) err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_shared_resource_arbiter.sv
// tb_shared_resource_arbiter: queue-based reference model compared every cycle plus directed literal checks
module tb_shared_resource_arbiter;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic reset;
    logic [DW-1:0] req_data_1, req_data_2, rsp_data_1, rsp_data_2, res_data, res_rsp_data;
    logic req_valid_1, req_flush_1, req_stall_1, rsp_valid_1, rsp_stall_1;
    logic req_valid_2, req_flush_2, req_stall_2, rsp_valid_2, rsp_stall_2;
    logic res_valid, res_stall, res_rsp_valid, res_rsp_stall, err_orphan;
    int n_cmp = 0;
    int n_bad = 0;

    shared_resource_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_data_1(req_data_1), .req_valid_1(req_valid_1), .req_flush_1(req_flush_1),
        .req_stall_1(req_stall_1), .rsp_data_1(rsp_data_1), .rsp_valid_1(rsp_valid_1),
        .rsp_stall_1(rsp_stall_1),
        .req_data_2(req_data_2), .req_valid_2(req_valid_2), .req_flush_2(req_flush_2),
        .req_stall_2(req_stall_2), .rsp_data_2(rsp_data_2), .rsp_valid_2(rsp_valid_2),
        .rsp_stall_2(rsp_stall_2),
        .res_data(res_data), .res_valid(res_valid), .res_stall(res_stall),
        .res_rsp_data(res_rsp_data), .res_rsp_valid(res_rsp_valid),
        .res_rsp_stall(res_rsp_stall), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        int owner;
        bit kill;
    } mtag_t;
    mtag_t q[$];
    bit m_valid = 0;
    bit m_err = 0;
    logic [DW-1:0] m_data = '0;
    int m_rr = 2;
    int g_w;
    bit g_pop;
    bit x_stall1, x_stall2, x_rv1, x_rv2, x_rstall;
    logic [DW-1:0] x_rd1, x_rd2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void calc();
        bit can;
        bit e1, e2;
        int o;
        can = (!m_valid || !res_stall) && q.size() < DEPTH;
        e1 = req_valid_1 && !req_flush_1;
        e2 = req_valid_2 && !req_flush_2;
        g_w = 0;
        if (can) begin
            if (e1 && e2) g_w = (m_rr == 1) ? 2 : 1;
            else if (e1) g_w = 1;
            else if (e2) g_w = 2;
        end
        x_stall1 = req_valid_1 && g_w != 1;
        x_stall2 = req_valid_2 && g_w != 2;
        x_rv1 = 0; x_rv2 = 0; x_rd1 = '0; x_rd2 = '0; x_rstall = 0; g_pop = 0;
        if (res_rsp_valid && q.size() > 0) begin
            o = q[0].owner;
            if (q[0].kill || (o == 1 ? req_flush_1 : req_flush_2)) begin
                g_pop = 1;
            end else begin
                if (o == 1) begin x_rv1 = 1; x_rd1 = res_rsp_data; end
                else begin x_rv2 = 1; x_rd2 = res_rsp_data; end
                x_rstall = (o == 1) ? rsp_stall_1 : rsp_stall_2;
                g_pop = !x_rstall;
            end
        end
    endfunction

    // reference model state advance
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_valid = 0; m_data = '0; m_rr = 2; m_err = 0;
        end else begin
            calc();
            foreach (q[i])
                if ((q[i].owner == 1 && req_flush_1) || (q[i].owner == 2 && req_flush_2)) q[i].kill = 1;
            if (res_rsp_valid && q.size() == 0) m_err = 1;
            if (g_pop) void'(q.pop_front());
            if (g_w != 0) begin
                q.push_back('{owner: g_w, kill: 1'b0});
                m_valid = 1;
                m_data = (g_w == 1) ? req_data_1 : req_data_2;
                m_rr = g_w;
            end else if (!m_valid || !res_stall) begin
                m_valid = 0;
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        calc();
        chk("m_req_stall_1", req_stall_1, x_stall1);
        chk("m_req_stall_2", req_stall_2, x_stall2);
        chk("m_rsp_valid_1", rsp_valid_1, x_rv1);
        chk("m_rsp_valid_2", rsp_valid_2, x_rv2);
        chk("m_rsp_data_1", rsp_data_1, x_rd1);
        chk("m_rsp_data_2", rsp_data_2, x_rd2);
        chk("m_res_rsp_stall", res_rsp_stall, x_rstall);
        chk("m_res_valid", res_valid, m_valid);
        chk("m_res_data", res_data, m_data);
        chk("m_err_orphan", err_orphan, m_err);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_data_1 = '0; req_valid_1 = 0; req_flush_1 = 0; rsp_stall_1 = 0;
        req_data_2 = '0; req_valid_2 = 0; req_flush_2 = 0; rsp_stall_2 = 0;
        res_stall = 0; res_rsp_data = '0; res_rsp_valid = 0;
    endtask

    task automatic do_reset();
        step();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #3;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_err", err_orphan, 0);
        // single requester
        step(); req_valid_1 = 1; req_data_1 = 32'hA5A5_0001;
        #3 chk("t1_accept", req_stall_1, 0);
        step(); req_valid_1 = 0;
        #3 chk("t1_res_valid", res_valid, 1);
        chk("t1_res_data", res_data, 32'hA5A5_0001);
        step(); res_rsp_valid = 1; res_rsp_data = 32'h99;
        #3 chk("t1_rsp_valid_1", rsp_valid_1, 1);
        chk("t1_rsp_data_1", rsp_data_1, 32'h99);
        step(); res_rsp_valid = 0;
        // alternating grants, then fill to full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            req_valid_1 = 1; req_valid_2 = 1;
            req_data_1 = 32'h100 + i; req_data_2 = 32'h200 + i;
            #3 chk("t2_stall_1", req_stall_1, i % 2);
            chk("t2_stall_2", req_stall_2, (i + 1) % 2);
            if (i > 0) chk("t2_res_data", res_data, ((i - 1) % 2 == 0) ? 32'h100 + i - 1 : 32'h200 + i - 1);
        end
        step(); req_valid_2 = 0; req_data_1 = 32'h555;
        #3 chk("t4_last_data", res_data, 32'h203);
        chk("t4_full_stall", req_stall_1, 1);
        step(); res_rsp_valid = 1; res_rsp_data = 32'hB0;
        #3 chk("t4_pop_no_accept", req_stall_1, 1);
        chk("t4_pop_owner", rsp_valid_1, 1);
        step(); res_rsp_valid = 0;
        #3 chk("t4_resume", req_stall_1, 0);
        step(); req_valid_1 = 0;
        #3 chk("t4_resume_data", res_data, 32'h555);
        step(); res_rsp_valid = 1; res_rsp_data = 32'hB1; rsp_stall_2 = 1;
        #3 chk("t4_bp_stall", res_rsp_stall, 1);
        chk("t4_bp_valid_2", rsp_valid_2, 1);
        step(); rsp_stall_2 = 0; res_rsp_data = 32'hB2;
        #3 chk("t4_bp_data_2", rsp_data_2, 32'hB2);
        chk("t4_bp_release", res_rsp_stall, 0);
        for (int i = 3; i < 6; i++) begin
            step(); res_rsp_data = 32'hB0 + i;
        end
        step(); res_rsp_valid = 0;
        // output register held under resource stall
        do_reset();
        step(); req_valid_1 = 1; req_data_1 = 32'h33; res_stall = 1;
        #3 chk("t3_accept", req_stall_1, 0);
        step(); req_data_1 = 32'h44; req_valid_2 = 1; req_data_2 = 32'h55;
        for (int j = 0; j < 3; j++) begin
            #3 chk("t3_hold_data", res_data, 32'h33);
            chk("t3_stall_1", req_stall_1, 1);
            chk("t3_stall_2", req_stall_2, 1);
            step();
        end
        res_stall = 0;
        #3 chk("t3_rr_p2", req_stall_2, 0);
        chk("t3_rr_p1", req_stall_1, 1);
        step(); req_valid_1 = 0; req_valid_2 = 0;
        #3 chk("t3_next_data", res_data, 32'h55);
        // flush drops pipeline 1 responses
        do_reset();
        step(); req_valid_1 = 1; req_data_1 = 32'h1;
        step(); req_valid_1 = 0; req_valid_2 = 1; req_data_2 = 32'h2;
        step(); req_valid_2 = 0; req_valid_1 = 1; req_data_1 = 32'h3;
        step(); req_valid_1 = 0; req_flush_1 = 1;
        step(); req_flush_1 = 0; res_rsp_valid = 1; res_rsp_data = 32'h11;
        #3 chk("t5_drop_v1", rsp_valid_1, 0);
        chk("t5_drop_v2", rsp_valid_2, 0);
        chk("t5_drop_stall", res_rsp_stall, 0);
        step(); res_rsp_data = 32'h22;
        #3 chk("t5_p2_valid", rsp_valid_2, 1);
        chk("t5_p2_data", rsp_data_2, 32'h22);
        step(); res_rsp_data = 32'h33;
        #3 chk("t5_drop_last", rsp_valid_1, 0);
        step(); res_rsp_valid = 0;
        // orphan response and asynchronous reset
        do_reset();
        step(); res_rsp_valid = 1; res_rsp_data = 32'hEE;
        step(); res_rsp_valid = 0;
        #3 chk("t6_err_set", err_orphan, 1);
        repeat (3) step();
        #3 chk("t6_err_sticky", err_orphan, 1);
        step(); req_valid_1 = 1; req_data_1 = 32'h77;
        step(); req_valid_1 = 0;
        #3 chk("t6_pre_reset_valid", res_valid, 1);
        reset = 1;
        #1 chk("t6_async_valid", res_valid, 0);
        chk("t6_async_data", res_data, 0);
        chk("t6_async_err", err_orphan, 0);
        step(); step(); reset = 0;
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
